// File: rtl/lfsr_pkg.sv
// Shared definitions for the game RNG: maximal-length XNOR tap table and FSM states.
package lfsr_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } rng_state_t;

  // Bit (n-1) of the mask selects tap n, where tap 1 is the newest bit.
  function automatic logic [15:0] TAPS(input int unsigned width);
    logic [15:0] m;
    m = '0;
    case (width)
      3:       m = 16'h0006;
      4:       m = 16'h000C;
      5:       m = 16'h0014;
      6:       m = 16'h0030;
      7:       m = 16'h0060;
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0829;
      13:      m = 16'h100D;
      14:      m = 16'h2015;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lfsr_rng_core.sv
// XNOR Fibonacci LFSR register with seed loading and all-ones lockup substitution.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state,
  output logic             lockup
);

  localparam logic [15:0]      LP_TAPS = TAPS(WIDTH);
  localparam logic [WIDTH-1:0] LP_ONES = '1;

  logic [WIDTH-1:0] r_state;
  logic             r_lockup;
  logic             w_fb;

  assign w_fb = ~(^(r_state & LP_TAPS[WIDTH-1:0]));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= '0;
      r_lockup <= 1'b0;
    end else begin
      r_lockup <= 1'b0;
      if (seed_load) begin
        if (seed == LP_ONES) begin
          r_state  <= '0;
          r_lockup <= 1'b1;
        end else begin
          r_state <= seed;
        end
      end else if (r_state == LP_ONES) begin
        // All-ones is a fixed point of an XNOR LFSR; escape it regardless of step.
        r_state  <= '0;
        r_lockup <= 1'b1;
      end else if (step) begin
        r_state <= {r_state[WIDTH-2:0], w_fb};
      end
    end
  end

  assign state  = r_state;
  assign lockup = r_lockup;

endmodule

// File: rtl/lfsr_rng.sv
// Game RNG: free-running LFSR plus a req/valid port returning a value below a
// runtime limit by rejection sampling, with a bounded number of tries.
module lfsr_rng
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned MAX_TRIES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  input  logic [OUT_W-1:0] limit,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] value,
  output logic             fallback,
  output logic [WIDTH-1:0] state,
  output logic             lockup
);

  if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
    $error("lfsr_rng: WIDTH must be within 3..16");
  end
  if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
    $error("lfsr_rng: OUT_W must be within 1..WIDTH");
  end
  if (MAX_TRIES < 1) begin : g_bad_tries
    $error("lfsr_rng: MAX_TRIES must be at least 1");
  end

  localparam int unsigned LP_AW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  rng_state_t       r_fsm;
  logic [OUT_W-1:0] r_limit;
  logic [OUT_W-1:0] r_value;
  logic [LP_AW-1:0] r_attempts;
  logic             r_busy;
  logic             r_valid;
  logic             r_fallback;

  logic             w_step;
  logic [OUT_W-1:0] w_cand;
  logic             w_hit;
  logic             w_last;

  assign w_step = (r_fsm == SEARCH) | enable;
  assign w_cand = state[OUT_W-1:0];
  assign w_hit  = (w_cand < r_limit);
  assign w_last = (r_attempts == LP_AW'(MAX_TRIES - 1));

  lfsr_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .step     (w_step),
    .seed_load(seed_load),
    .seed     (seed),
    .state    (state),
    .lockup   (lockup)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm      <= IDLE;
      r_limit    <= '0;
      r_value    <= '0;
      r_attempts <= '0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_fallback <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_fsm)
        IDLE: begin
          if (req) begin
            r_limit    <= limit;
            r_attempts <= '0;
            if (limit == '0) begin
              r_value    <= '0;
              r_fallback <= 1'b1;
              r_valid    <= 1'b1;
            end else begin
              r_fsm  <= SEARCH;
              r_busy <= 1'b1;
            end
          end
        end
        SEARCH: begin
          if (w_hit) begin
            r_value    <= w_cand;
            r_fallback <= 1'b0;
            r_valid    <= 1'b1;
            r_fsm      <= IDLE;
            r_busy     <= 1'b0;
          end else if (w_last) begin
            r_value    <= '0;
            r_fallback <= 1'b1;
            r_valid    <= 1'b1;
            r_fsm      <= IDLE;
            r_busy     <= 1'b0;
          end else begin
            r_attempts <= r_attempts + 1'b1;
          end
        end
        default: begin
          r_fsm  <= IDLE;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign valid    = r_valid;
  assign value    = r_value;
  assign fallback = r_fallback;

endmodule

// File: tb/tb_lfsr_rng.sv
// Self-checking bench for lfsr_rng: directed scenarios, a randomized transaction
// test against a behavioural model, and a parallel period sweep over widths 3..16.
module tb_lfsr_rng;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       sl = 1'b0;
  logic [9:0] sd = '0;
  logic       rq = 1'b0;
  logic [7:0] lim = '0;
  logic       busy, valid, fb, lk;
  logic [7:0] value;
  logic [9:0] st;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lfsr_rng #(
    .WIDTH(10),
    .OUT_W(8),
    .MAX_TRIES(4)
  ) dut (
    .clk(clk), .reset(rst), .enable(en), .seed_load(sl), .seed(sd),
    .req(rq), .limit(lim), .busy(busy), .valid(valid), .value(value),
    .fallback(fb), .state(st), .lockup(lk)
  );

  // Free-running instances of every legal width, used for the period sweep.
  logic        sw_rst = 1'b1;
  logic [15:0] sw_st   [3:16];
  logic [4:0]  sw_flags[3:16];

  for (genvar g = 3; g <= 16; g++) begin : g_sw
    logic [g-1:0] w_s;
    logic         w_b, w_v, w_f, w_l;
    logic [0:0]   w_val;
    lfsr_rng #(
      .WIDTH(g),
      .OUT_W(1),
      .MAX_TRIES(1)
    ) u_sw (
      .clk(clk), .reset(sw_rst), .enable(1'b1), .seed_load(1'b0), .seed('0),
      .req(1'b0), .limit(1'b0), .busy(w_b), .valid(w_v), .value(w_val),
      .fallback(w_f), .state(w_s), .lockup(w_l)
    );
    assign sw_st[g]    = 16'(w_s);
    assign sw_flags[g] = {w_b, w_v, w_f, w_l, w_val[0]};
  end

  // Reference step for the 10-bit generator: shift left, new bit = XNOR(tap10, tap7).
  function automatic int unsigned m_next10(input int unsigned s);
    int unsigned d;
    if (s == 32'h3FF) return 0;
    d = 1 ^ ((s >> 9) & 1) ^ ((s >> 6) & 1);
    return ((s << 1) | d) & 32'h3FF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; en = 1'b0; sl = 1'b0; rq = 1'b0; lim = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; rq = 1'b1; lim = 8'd5; sl = 1'b0;
    tick(); tick();
    checks++; if (st !== 10'h000) begin errs++; $display("FAIL reset_state got=%0h want=0", st); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%0b want=0", busy); end
    checks++; if (valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%0b want=0", valid); end
    checks++; if (value !== 8'h00) begin errs++; $display("FAIL reset_value got=%0h want=0", value); end
    checks++; if (fb !== 1'b0) begin errs++; $display("FAIL reset_fallback got=%0b want=0", fb); end
    checks++; if (lk !== 1'b0) begin errs++; $display("FAIL reset_lockup got=%0b want=0", lk); end
    rq = 1'b0; en = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_period();
    bit          seen[1024];
    int unsigned e;
    int unsigned first_c [1:3];
    bit          saw_ones, saw_repeat;
    first_c = '{32'h001, 32'h003, 32'h007};
    saw_ones = 1'b0; saw_repeat = 1'b0;
    foreach (seen[i]) seen[i] = 1'b0;
    apply_reset();
    en = 1'b1;
    e = 0;
    seen[0] = 1'b1;
    for (int n = 1; n <= 1023; n++) begin
      tick();
      e = m_next10(e);
      if (n <= 3) begin
        checks++;
        if (st !== first_c[n][9:0]) begin errs++; $display("FAIL period_start%0d got=%0h want=%0h", n, st, first_c[n]); end
      end
      checks++;
      if (st !== e[9:0]) begin errs++; $display("FAIL period_step%0d got=%0h want=%0h", n, st, e); end
      if (st === 10'h3FF) saw_ones = 1'b1;
      if (n < 1023) begin
        if (seen[st]) saw_repeat = 1'b1;
        seen[st] = 1'b1;
      end
    end
    checks++; if (st !== 10'h000) begin errs++; $display("FAIL period_wrap got=%0h want=0", st); end
    checks++; if (saw_ones !== 1'b0) begin errs++; $display("FAIL period_allones got=%0b want=0", saw_ones); end
    checks++; if (saw_repeat !== 1'b0) begin errs++; $display("FAIL period_repeat got=%0b want=0", saw_repeat); end
    en = 1'b0;
  endtask

  task automatic test_lockup();
    apply_reset();
    sl = 1'b1; sd = 10'h3FF;
    tick();
    sl = 1'b0;
    checks++; if (st !== 10'h000) begin errs++; $display("FAIL lockup_state got=%0h want=0", st); end
    checks++; if (lk !== 1'b1) begin errs++; $display("FAIL lockup_pulse got=%0b want=1", lk); end
    tick();
    checks++; if (lk !== 1'b0) begin errs++; $display("FAIL lockup_width got=%0b want=0", lk); end
    sl = 1'b1; sd = 10'h155;
    tick();
    sl = 1'b0;
    checks++; if (st !== 10'h155) begin errs++; $display("FAIL seed_state got=%0h want=155", st); end
    checks++; if (lk !== 1'b0) begin errs++; $display("FAIL seed_nolockup got=%0b want=0", lk); end
  endtask

  task automatic test_immediate_hit();
    apply_reset();
    rq = 1'b1; lim = 8'd64;
    tick();
    rq = 1'b0;
    checks++; if ({busy, valid} !== 2'b10) begin errs++; $display("FAIL hit_busy got=%b want=10", {busy, valid}); end
    tick();
    checks++; if ({busy, valid, fb} !== 3'b010) begin errs++; $display("FAIL hit_flags got=%b want=010", {busy, valid, fb}); end
    checks++; if (value !== 8'h00) begin errs++; $display("FAIL hit_value got=%0h want=0", value); end
    tick();
    checks++; if (valid !== 1'b0) begin errs++; $display("FAIL hit_pulse got=%0b want=0", valid); end
  endtask

  task automatic test_fallback();
    apply_reset();
    sl = 1'b1; sd = 10'h001;
    tick();
    sl = 1'b0; rq = 1'b1; lim = 8'd1;
    tick();
    rq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({busy, valid} !== 2'b10) begin errs++; $display("FAIL fb_search%0d got=%b want=10", i, {busy, valid}); end
      tick();
    end
    checks++; if ({busy, valid, fb} !== 3'b011) begin errs++; $display("FAIL fb_flags got=%b want=011", {busy, valid, fb}); end
    checks++; if (value !== 8'h00) begin errs++; $display("FAIL fb_value got=%0h want=0", value); end
    checks++; if (st !== 10'h01F) begin errs++; $display("FAIL fb_state got=%0h want=1f", st); end
  endtask

  task automatic test_limit_zero();
    apply_reset();
    sl = 1'b1; sd = 10'h155;
    tick();
    sl = 1'b0; rq = 1'b1; lim = 8'd0;
    tick();
    rq = 1'b0;
    checks++; if ({busy, valid, fb} !== 3'b011) begin errs++; $display("FAIL lim0_flags got=%b want=011", {busy, valid, fb}); end
    checks++; if (value !== 8'h00) begin errs++; $display("FAIL lim0_value got=%0h want=0", value); end
    checks++; if (st !== 10'h155) begin errs++; $display("FAIL lim0_state got=%0h want=155", st); end
    tick();
    checks++; if (valid !== 1'b0) begin errs++; $display("FAIL lim0_pulse got=%0b want=0", valid); end
  endtask

  task automatic test_busy_req_ignored();
    int nvalid;
    apply_reset();
    sl = 1'b1; sd = 10'h001;
    tick();
    sl = 1'b0; rq = 1'b1; lim = 8'd1;
    tick();
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        rq = 1'b1; lim = 8'($urandom_range(1, 255));
      end else begin
        rq = 1'b0;
      end
      tick();
      if (valid === 1'b1) nvalid++;
    end
    checks++; if (nvalid !== 1) begin errs++; $display("FAIL busy_req_valids got=%0d want=1", nvalid); end
    checks++; if ({busy, fb} !== 2'b01) begin errs++; $display("FAIL busy_req_end got=%b want=01", {busy, fb}); end
  endtask

  task automatic test_reset_mid_search();
    bit stray;
    apply_reset();
    sl = 1'b1; sd = 10'h001;
    tick();
    sl = 1'b0; rq = 1'b1; lim = 8'd1;
    tick();
    rq = 1'b0;
    tick();
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL rstmid_busy got=%0b want=1", busy); end
    rst = 1'b1;
    tick();
    checks++; if ({busy, valid} !== 2'b00) begin errs++; $display("FAIL rstmid_flags got=%b want=00", {busy, valid}); end
    checks++; if (st !== 10'h000) begin errs++; $display("FAIL rstmid_state got=%0h want=0", st); end
    rst = 1'b0;
    stray = 1'b0;
    repeat (6) begin
      tick();
      if (valid !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) begin errs++; $display("FAIL rstmid_stray got=%0b want=0", stray); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    rq = 1'b1; lim = 8'd64;
    tick();
    rq = 1'b0;
    tick();
    checks++; if (valid !== 1'b1) begin errs++; $display("FAIL b2b_first got=%0b want=1", valid); end
    rq = 1'b1; lim = 8'd64;
    tick();
    rq = 1'b0;
    checks++; if ({busy, valid} !== 2'b10) begin errs++; $display("FAIL b2b_accept got=%b want=10", {busy, valid}); end
    tick();
    checks++; if ({valid, fb} !== 2'b10) begin errs++; $display("FAIL b2b_second got=%b want=10", {valid, fb}); end
    checks++; if (value !== 8'h01) begin errs++; $display("FAIL b2b_value got=%0h want=1", value); end
  endtask

  task automatic test_seed_during_search();
    apply_reset();
    sl = 1'b1; sd = 10'h0FF;
    tick();
    sl = 1'b0; rq = 1'b1; lim = 8'd16;
    tick();
    rq = 1'b0; sl = 1'b1; sd = 10'h205;
    tick();
    sl = 1'b0;
    checks++; if ({busy, valid} !== 2'b10) begin errs++; $display("FAIL sds_busy got=%b want=10", {busy, valid}); end
    checks++; if (st !== 10'h205) begin errs++; $display("FAIL sds_state got=%0h want=205", st); end
    tick();
    checks++; if ({valid, fb} !== 2'b10) begin errs++; $display("FAIL sds_flags got=%b want=10", {valid, fb}); end
    checks++; if (value !== 8'h05) begin errs++; $display("FAIL sds_value got=%0h want=5", value); end
    // Reloading a rejected seed every cycle must still exhaust the try budget.
    sl = 1'b1; sd = 10'h0FF;
    tick();
    rq = 1'b1; lim = 8'd16;
    tick();
    rq = 1'b0;
    repeat (3) tick();
    checks++; if ({busy, valid} !== 2'b10) begin errs++; $display("FAIL sds_hold got=%b want=10", {busy, valid}); end
    tick();
    sl = 1'b0;
    checks++; if ({valid, fb} !== 2'b11) begin errs++; $display("FAIL sds_fallback got=%b want=11", {valid, fb}); end
  endtask

  task automatic test_random();
    int unsigned ms, s, expv, k, gap;
    bit          hit, exp_lk;
    apply_reset();
    ms = 0;
    for (int t = 0; t < 80; t++) begin
      gap = $urandom_range(0, 4);
      for (int g = 0; g < int'(gap); g++) begin
        rq = 1'b0;
        en = 1'($urandom_range(0, 1));
        sl = ($urandom_range(0, 5) == 0);
        sd = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom);
        tick();
        exp_lk = sl && (sd == 10'h3FF);
        if (sl) ms = (sd == 10'h3FF) ? 0 : 32'(sd);
        else if (en) ms = m_next10(ms);
        sl = 1'b0;
        checks++; if (st !== ms[9:0]) begin errs++; $display("FAIL rnd_idle_state t=%0d got=%0h want=%0h", t, st, ms); end
        checks++; if ({valid, lk} !== {1'b0, exp_lk}) begin errs++; $display("FAIL rnd_idle_flags t=%0d got=%b want=%b", t, {valid, lk}, {1'b0, exp_lk}); end
      end
      en = 1'($urandom_range(0, 1));
      rq = 1'b1;
      lim = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 8)) : 8'($urandom_range(0, 255));
      tick();
      if (en) ms = m_next10(ms);
      rq = 1'b0;
      if (lim == 8'd0) begin
        checks++; if ({busy, valid, fb, value} !== {3'b011, 8'h00}) begin errs++; $display("FAIL rnd_lim0 t=%0d got=%b/%0h want=011/0", t, {busy, valid, fb}, value); end
        checks++; if (st !== ms[9:0]) begin errs++; $display("FAIL rnd_lim0_state t=%0d got=%0h want=%0h", t, st, ms); end
      end else begin
        s = ms; hit = 1'b0; k = 3; expv = 0;
        for (int i = 0; i < 4; i++) begin
          if ((s & 32'hFF) < 32'(lim)) begin hit = 1'b1; k = i; expv = s & 32'hFF; break; end
          s = m_next10(s);
        end
        for (int i = 0; i <= int'(k); i++) begin
          checks++; if ({busy, valid} !== 2'b10) begin errs++; $display("FAIL rnd_busy t=%0d i=%0d got=%b want=10", t, i, {busy, valid}); end
          en = 1'($urandom_range(0, 1));
          rq = 1'($urandom_range(0, 1));
          lim = 8'($urandom);
          tick();
          ms = m_next10(ms);
        end
        rq = 1'b0;
        checks++; if ({busy, valid, fb} !== {2'b01, ~hit}) begin errs++; $display("FAIL rnd_done t=%0d got=%b want=%b", t, {busy, valid, fb}, {2'b01, ~hit}); end
        checks++; if (value !== expv[7:0]) begin errs++; $display("FAIL rnd_value t=%0d got=%0h want=%0h", t, value, expv); end
        checks++; if (st !== ms[9:0]) begin errs++; $display("FAIL rnd_state t=%0d got=%0h want=%0h", t, st, ms); end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_width_sweep();
    int unsigned first[3:16];
    logic [4:0]  fl[3:16];
    for (int w = 3; w <= 16; w++) begin first[w] = 0; fl[w] = '0; end
    sw_rst = 1'b1;
    tick(); tick();
    sw_rst = 1'b0;
    for (int c = 1; c <= 65600; c++) begin
      tick();
      for (int w = 3; w <= 16; w++) begin
        fl[w] = fl[w] | sw_flags[w];
        if (first[w] == 0 && sw_st[w] == 16'h0000) first[w] = c;
      end
      if (first[16] != 0) break;
    end
    for (int w = 3; w <= 16; w++) begin
      checks++;
      if (first[w] !== (32'd1 << w) - 1) begin errs++; $display("FAIL sweep_period w=%0d got=%0d want=%0d", w, first[w], (32'd1 << w) - 1); end
      checks++;
      if (fl[w] !== 5'b0) begin errs++; $display("FAIL sweep_flags w=%0d got=%b want=0", w, fl[w]); end
    end
  endtask

  initial begin
    test_reset();
    test_period();
    test_lockup();
    test_immediate_hit();
    test_fallback();
    test_limit_zero();
    test_busy_req_ignored();
    test_reset_mid_search();
    test_back_to_back();
    test_seed_during_search();
    test_random();
    test_width_sweep();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
